// File: rtl/rr_mux16_arbiter_pkg.sv
// Shared types and helpers for the 16-way round-robin mux arbiter.
package rr_mux16_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  // Arbiter phases: no owner, owner active, one-cycle turnaround
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Expand a requester index into a one-hot grant vector
  function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] sel);
    return 16'd1 << sel;
  endfunction

endpackage

// File: rtl/rr_mux16_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface rr_mux16_arbiter_if;
  import rr_mux16_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data_in;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             gnt_valid;
  logic             out;

  // Requester side: raises requests and supplies data bits
  modport master (
    output req,
    output data_in,
    input  sel,
    input  grant,
    input  gnt_valid,
    input  out
  );

  // Arbiter side: consumes requests, drives grant and channel output
  modport slave (
    input  req,
    input  data_in,
    output sel,
    output grant,
    output gnt_valid,
    output out
  );
endinterface

// File: rtl/mux16x1_using_4x1.sv
// Team datapath: 16:1 bit mux built from a tree of 4:1 muxes.
module mux4x1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  // Plain 4-way selection
  always_comb begin
    case (sel)
      2'd0:    out = in[0];
      2'd1:    out = in[1];
      2'd2:    out = in[2];
      2'd3:    out = in[3];
      default: out = 1'b0;
    endcase
  end

endmodule

module mux16x1_using_4x1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  logic [3:0] lvl1_s;

  mux4x1 u_m0 (.in(in[3:0]),   .sel(sel[1:0]), .out(lvl1_s[0]));
  mux4x1 u_m1 (.in(in[7:4]),   .sel(sel[1:0]), .out(lvl1_s[1]));
  mux4x1 u_m2 (.in(in[11:8]),  .sel(sel[1:0]), .out(lvl1_s[2]));
  mux4x1 u_m3 (.in(in[15:12]), .sel(sel[1:0]), .out(lvl1_s[3]));
  mux4x1 u_m4 (.in(lvl1_s),    .sel(sel[3:2]), .out(out));

endmodule

// File: rtl/rr_mux16_arbiter_pick16.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick16
  import rr_mux16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] off_s;

  // Scan downward so the smallest offset from ptr wins
  always_comb begin
    off_s = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[ptr + 4'(i)]) begin
        off_s = 4'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  assign any = |req;
  assign idx = ptr + off_s;

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin owner of a shared 16:1 mux channel with bounded bursts
// and a one-cycle idle turnaround on every handover.
module rr_mux16_arbiter
  import rr_mux16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst,
  rr_mux16_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [7:0]       hold_cnt_r;
  logic [SEL_W-1:0] sel_r;
  logic [N_REQ-1:0] grant_r;
  logic             gnt_valid_r;

  logic             pick_any_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             own_req_s;
  logic             others_s;
  logic             hold_max_s;
  logic             mux_out_s;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Current owner still asking, anyone else asking, burst limit reached
  always_comb begin
    own_req_s  = bus.req[sel_r];
    others_s   = |(bus.req & ~onehot16(sel_r));
    hold_max_s = (hold_cnt_r == MAX_HOLD_C);
  end

  // Arbitration FSM; grant/sel/gnt_valid are registered with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 4'd0;
      hold_cnt_r  <= 8'd0;
      sel_r       <= 4'd0;
      grant_r     <= 16'd0;
      gnt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, GAP: begin
          // ptr was already advanced when the previous owner released
          if (pick_any_s) begin
            state_r     <= GRANT;
            sel_r       <= pick_idx_s;
            grant_r     <= onehot16(pick_idx_s);
            gnt_valid_r <= 1'b1;
            hold_cnt_r  <= 8'd1;
          end else begin
            state_r     <= IDLE;
            grant_r     <= 16'd0;
            gnt_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (!own_req_s || (hold_max_s && others_s)) begin
            // Release (voluntary or forced); sel keeps the last owner
            state_r     <= GAP;
            ptr_r       <= sel_r + 4'd1;
            grant_r     <= 16'd0;
            gnt_valid_r <= 1'b0;
          end else if (hold_max_s) begin
            // Nobody else waiting: keep the channel, counter saturates
            state_r     <= GRANT;
            hold_cnt_r  <= MAX_HOLD_C;
          end else begin
            state_r     <= GRANT;
            hold_cnt_r  <= hold_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          ptr_r       <= 4'd0;
          hold_cnt_r  <= 8'd0;
          grant_r     <= 16'd0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  mux16x1_using_4x1 u_mux (
    .in  (bus.data_in),
    .sel (sel_r),
    .out (mux_out_s)
  );

  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.out       = mux_out_s & gnt_valid_r;

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// Scoreboard bench for rr_mux16_arbiter: stimulus pushes model predictions,
// a monitor pops and compares them against the DUT after each rising edge.
module tb_rr_mux16_arbiter;

  localparam int MAX_HOLD_TB = 8;
  localparam int STARVE_LIM  = 15 * (MAX_HOLD_TB + 1);

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        gv;
    logic        out_v;
    int          expg;
  } exp_t;

  logic clk;
  logic rst;
  rr_mux16_arbiter_if bus ();

  rr_mux16_arbiter #(.MAX_HOLD(MAX_HOLD_TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  // Reference model: who owns the channel, how long, and where the scan starts
  int m_owner = -1;
  int m_held  = 0;
  int m_start = 0;
  int m_sel   = 0;

  function automatic void model_step(input bit r, input logic [15:0] rq);
    int found;
    if (r) begin
      m_owner = -1; m_held = 0; m_start = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      if (!rq[m_owner] ||
          (m_held == MAX_HOLD_TB && (rq & ~(16'd1 << m_owner)) != 16'd0)) begin
        m_start = (m_owner + 1) % 16;
        m_owner = -1;
      end else if (m_held < MAX_HOLD_TB) begin
        m_held = m_held + 1;
      end
    end else begin
      found = -1;
      for (int k = 0; k < 16; k++) begin
        if (found < 0 && rq[(m_start + k) % 16]) found = (m_start + k) % 16;
      end
      if (found >= 0) begin
        m_owner = found; m_held = 1; m_sel = found;
      end
    end
  endfunction

  task automatic step(input bit r, input logic [15:0] rq, input int expg);
    exp_t        it;
    logic [15:0] d;
    @(negedge clk);
    d = 16'($urandom());
    rst = r;
    bus.req = rq;
    bus.data_in = d;
    model_step(r, rq);
    it.rst   = r;
    it.req   = rq;
    it.gv    = (m_owner >= 0);
    it.grant = it.gv ? (16'd1 << m_owner) : 16'd0;
    it.sel   = 4'(m_sel);
    it.out_v = it.gv & d[m_sel];
    it.expg  = expg;
    started  = 1'b1;
    exp_q.push_back(it);
  endtask

  // Monitor: compare DUT against the oldest prediction, plus invariants
  int          wait_c[16];
  logic [15:0] prev_grant = 16'd0;
  initial begin
    exp_t it;
    for (int k = 0; k < 16; k++) wait_c[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (started) begin
          checks++; errors++;
          $display("FAIL noexp: no prediction queued at %0t", $time);
        end
      end else begin
        it = exp_q.pop_front();
        checks++;
        if (bus.grant !== it.grant || bus.sel !== it.sel ||
            bus.gnt_valid !== it.gv || bus.out !== it.out_v) begin
          errors++;
          $display("FAIL model @%0t: got grant=%h sel=%0d gv=%b out=%b, want grant=%h sel=%0d gv=%b out=%b",
                   $time, bus.grant, bus.sel, bus.gnt_valid, bus.out,
                   it.grant, it.sel, it.gv, it.out_v);
        end
        if (it.expg >= 0) begin
          checks++;
          if (bus.grant !== 16'(it.expg)) begin
            errors++;
            $display("FAIL directed @%0t: got grant=%h want %h", $time, bus.grant, 16'(it.expg));
          end
        end
        checks++;
        if ((bus.grant & (bus.grant - 16'd1)) != 16'd0 ||
            bus.out !== (bus.gnt_valid & bus.data_in[bus.sel]) ||
            (bus.gnt_valid && bus.grant !== (16'd1 << bus.sel))) begin
          errors++;
          $display("FAIL invariant @%0t: grant=%h sel=%0d gv=%b out=%b",
                   $time, bus.grant, bus.sel, bus.gnt_valid, bus.out);
        end
        checks++;
        if (prev_grant != 16'd0 && bus.grant != 16'd0 && prev_grant != bus.grant) begin
          errors++;
          $display("FAIL gap @%0t: grant %h followed by %h", $time, prev_grant, bus.grant);
        end
        prev_grant = bus.grant;
        for (int k = 0; k < 16; k++) begin
          if (it.rst || !it.req[k] || bus.grant[k]) wait_c[k] = 0;
          else wait_c[k] = wait_c[k] + 1;
          if (wait_c[k] > STARVE_LIM) begin
            checks++; errors++;
            $display("FAIL starve: req %0d waited %0d cycles, limit %0d", k, wait_c[k], STARVE_LIM);
            wait_c[k] = 0;
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios then sticky random requests
  initial begin
    logic [15:0] cur;
    int          e;
    rst = 1'b1;
    bus.req = 16'd0;
    bus.data_in = 16'd0;

    // Reset release, no requests
    step(1'b1, 16'h0000, -1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 0);

    // Two requesters alternate under forced rotation
    step(1'b1, 16'h0000, -1);
    for (int c = 0; c < 19; c++) begin
      e = (c < 8) ? 16'h0004 : (c == 8) ? 0 : (c < 17) ? 16'h0020 : (c == 17) ? 0 : 16'h0004;
      step(1'b0, 16'h0024, e);
    end

    // Lone requester keeps the channel indefinitely
    step(1'b1, 16'h0000, -1);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0200, 16'h0200);

    // Pointer wrap 15 -> 0
    step(1'b1, 16'h0000, -1);
    step(1'b0, 16'h4000, 16'h4000);
    step(1'b0, 16'h4000, 16'h4000);
    step(1'b0, 16'h8001, 0);
    step(1'b0, 16'h8001, 16'h8000);
    step(1'b0, 16'h8001, 16'h8000);
    step(1'b0, 16'h0001, 0);
    step(1'b0, 16'h0001, 16'h0001);

    // Reset in the middle of a burst
    step(1'b1, 16'h0000, -1);
    step(1'b0, 16'h0008, 16'h0008);
    step(1'b0, 16'h0008, 16'h0008);
    step(1'b0, 16'h0008, 16'h0008);
    step(1'b1, 16'h0018, 0);
    step(1'b0, 16'h0018, 16'h0008);

    // Random sticky requests
    cur = 16'd0;
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(15, 0) == 0) cur[k] = ~cur[k];
      end
      step(1'b0, cur, -1);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
